banco_registradores_ctx: RTL
============================

Name: banco_registradores_ctx

Overview:
- Parametrised successor of the CPU register bank, with configurable width and depth.
- Two write ports, write-through read bypass and a dedicated observation output.
- Context save/restore to a shadow bank, run by a sequencer that copies one register per cycle.
- Sits between decode and writeback; the shadow bank serves interrupt/trap context switches.

Parameters:
LARGURA, 8, data width in bits
NUM_REGS, 8, number of registers (2..2**END_BITS)
END_BITS, 3, register address width
REG_DEDICADO, 7, index driven onto DadoDedicado (a0)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
RegLido1  input  END_BITS  read address, port 1
RegLido2  input  END_BITS  read address, port 2
DadoLido1  output  LARGURA  read data, port 1
DadoLido2  output  LARGURA  read data, port 2
RegEscrito  input  END_BITS  write address, port A
DadoEscrito  input  LARGURA  write data, port A
EscReg  input  1  write enable, port A
RegEscrito2  input  END_BITS  write address, port B
DadoEscrito2  input  LARGURA  write data, port B
EscReg2  input  1  write enable, port B
Salvar  input  1  start save: bank -> shadow
Restaurar  input  1  start restore: shadow -> bank
Ocupado  output  1  sequencer busy
ErroEscrita  output  1  one-cycle pulse: a write was dropped
DadoDedicado  output  LARGURA  contents of REG[REG_DEDICADO]

Behaviour:
- Reset (sync, high): all REG and SOMBRA entries cleared to 0; FSM goes to OCIOSO, index counter to 0; Ocupado=0, ErroEscrita=0. Reset mid-sequence aborts the sequence with no partial result kept.
- Reads are combinational on address.
  - If FSM is OCIOSO and a same-cycle enabled write targets the read address, DadoLido shows the write data (bypass).
  - If both ports write that address, port B data is bypassed.
- Writes commit on the rising edge. If both ports hit the same address, port B wins.
- Address >= NUM_REGS: reads return 0; writes are ignored and do not raise an error.
- DadoDedicado reflects stored state only (no bypass): it shows the new value the cycle after the write.
- FSM states: OCIOSO, SALVANDO, RESTAURANDO.
  - OCIOSO + Salvar -> SALVANDO. OCIOSO + Restaurar -> RESTAURANDO. Both asserted together: Salvar wins.
  - SALVANDO: each cycle copies SOMBRA[i] <= REG[i], i++. After i = NUM_REGS-1, returns to OCIOSO and clears i.
  - RESTAURANDO: same sequence with REG[i] <= SOMBRA[i].
  - Salvar/Restaurar while busy: ignored, not queued.
- Ocupado is registered and equals (state != OCIOSO). It is high exactly NUM_REGS cycles, starting the cycle after the command.
- A write in the same cycle as Salvar is accepted (FSM still OCIOSO) and is included in the saved context.
- While Ocupado=1:
  - Writes on either port are dropped.
  - ErroEscrita pulses high the following cycle, once per dropped cycle even if both ports wrote.
  - Bypass is disabled.
- Reads during RESTAURANDO return the current, partially restored bank contents.

Optional Feature:
BANCO_REG_ZERO_EN
- Defined: register 0 is hardwired to zero.
  - Reads of address 0 always return 0, including bypass.
  - Writes to 0 are silently ignored and do not raise ErroEscrita.
  - Restore leaves REG[0]=0; SOMBRA[0] always saves 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset, then read all addresses -> DadoLido1/2 = 0, DadoDedicado = 0, Ocupado = 0.
- EscReg=1, RegEscrito=3, DadoEscrito=8'hA5, RegLido1=3 in the same cycle -> DadoLido1 = A5 that cycle (bypass), still A5 next cycle.
- Both ports write address 2 (A=8'h11, B=8'h22) -> REG[2] = 22; REG[7] = 8'h5A -> DadoDedicado = 5A one cycle later.
- Fill REG[i]=i+1, pulse Salvar, overwrite all with 0, pulse Restaurar -> Ocupado high 8 cycles each time; REG[i]=i+1 restored.
- During SALVANDO write REG[4]=8'hFF -> write dropped, ErroEscrita pulses exactly one cycle later, REG[4] unchanged; Restaurar during SALVANDO is ignored.
- Assert Reset at cycle 3 of RESTAURANDO -> next cycle Ocupado = 0 and all registers read 0; with BANCO_REG_ZERO_EN, a write of 8'h77 to address 0 reads back 0.

Source files
------------

// File: rtl/banco_registradores_ctx.sv
// banco_registradores_ctx: parametrised register bank with two write ports,
// write-through read bypass, a dedicated observation output and a shadow bank
// for context save/restore driven by a one-register-per-cycle sequencer.
// Optional build macro: BANCO_REG_ZERO_EN (register 0 hardwired to zero).
module banco_registradores_ctx #(
   parameter int LARGURA      = 8,
   parameter int NUM_REGS     = 8,
   parameter int END_BITS     = 3,
   parameter int REG_DEDICADO = 7
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [END_BITS-1:0] RegLido1,
   input  logic [END_BITS-1:0] RegLido2,
   output logic [LARGURA-1:0]  DadoLido1,
   output logic [LARGURA-1:0]  DadoLido2,
   input  logic [END_BITS-1:0] RegEscrito,
   input  logic [LARGURA-1:0]  DadoEscrito,
   input  logic                EscReg,
   input  logic [END_BITS-1:0] RegEscrito2,
   input  logic [LARGURA-1:0]  DadoEscrito2,
   input  logic                EscReg2,
   input  logic                Salvar,
   input  logic                Restaurar,
   output logic                Ocupado,
   output logic                ErroEscrita,
   output logic [LARGURA-1:0]  DadoDedicado
);

`ifdef BANCO_REG_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   localparam logic [END_BITS-1:0] ULTIMO = END_BITS'(NUM_REGS - 1);

   typedef enum logic [1:0] {
      OCIOSO,
      SALVANDO,
      RESTAURANDO
   } estado_t;

   estado_t             state_q, state_d;
   logic [END_BITS-1:0] idx_q, idx_d;
   logic                ocupado_q, ocupado_d;
   logic                erro_q, erro_d;

   logic [LARGURA-1:0]  reg_q    [NUM_REGS];
   logic [LARGURA-1:0]  reg_d    [NUM_REGS];
   logic [LARGURA-1:0]  sombra_q [NUM_REGS];
   logic [LARGURA-1:0]  sombra_d [NUM_REGS];

   logic                ocioso;
   logic                esc_a_ok;
   logic                esc_b_ok;

   // An address is usable when it names an implemented, writable register.
   function automatic logic endereco_ok(input logic [END_BITS-1:0] a);
      endereco_ok = ({1'b0, a} < (END_BITS + 1)'(NUM_REGS)) && !(ZERO_EN && (a == '0));
   endfunction

   // Combinational read with write-through bypass; port B has priority.
   function automatic logic [LARGURA-1:0] ler(input logic [END_BITS-1:0] a);
      if (!endereco_ok(a))                       return '0;
      if (ocioso && esc_b_ok && RegEscrito2 == a) return DadoEscrito2;
      if (ocioso && esc_a_ok && RegEscrito == a)  return DadoEscrito;
      return reg_q[a];
   endfunction

   assign ocioso   = (state_q == OCIOSO);
   assign esc_a_ok = EscReg  && endereco_ok(RegEscrito);
   assign esc_b_ok = EscReg2 && endereco_ok(RegEscrito2);

   // State register for the save/restore sequencer and its registered flags.
   always_ff @(posedge Clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (Reset) begin
         state_q   <= OCIOSO;
         idx_q     <= '0;
         ocupado_q <= 1'b0;
         erro_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ocupado_q <= ocupado_d;
         erro_q    <= erro_d;
      end
   end

   // Next-state logic: start on command when idle, walk the index while busy.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         OCIOSO: begin
            if (Salvar) begin
               state_d = SALVANDO;
            end else if (Restaurar) begin
               state_d = RESTAURANDO;
            end
            idx_d = '0;
         end
         SALVANDO, RESTAURANDO: begin
            if (idx_q == ULTIMO) begin
               state_d = OCIOSO;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = OCIOSO;
            idx_d   = '0;
         end
      endcase
   end

   // Output logic: busy flag follows the next state, error flags dropped writes.
   always_comb begin
      ocupado_d = (state_d != OCIOSO);
      erro_d    = !ocioso && (esc_a_ok || esc_b_ok);
   end

   // Next contents of the bank and shadow: port writes when idle, else copy.
   always_comb begin
      reg_d    = reg_q;
      sombra_d = sombra_q;
      unique case (state_q)
         OCIOSO: begin
            if (esc_a_ok) reg_d[RegEscrito]  = DadoEscrito;
            if (esc_b_ok) reg_d[RegEscrito2] = DadoEscrito2;
         end
         SALVANDO: begin
            sombra_d[idx_q] = reg_q[idx_q];
         end
         RESTAURANDO: begin
            if (!(ZERO_EN && (idx_q == '0))) reg_d[idx_q] = sombra_q[idx_q];
         end
         default: begin
            reg_d    = reg_q;
            sombra_d = sombra_q;
         end
      endcase
   end

   // Bank and shadow storage, cleared by reset.
   always_ff @(posedge Clock) begin
      // NOTE: these arrays are reset explicitly because the context contents
      // must be known zero after reset; this rules out RAM macro inference.
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i]    <= '0;
            sombra_q[i] <= '0;
         end
      end else begin
         reg_q    <= reg_d;
         sombra_q <= sombra_d;
      end
   end

   // Read ports.
   always_comb begin
      DadoLido1 = ler(RegLido1);
      DadoLido2 = ler(RegLido2);
   end

   assign DadoDedicado = reg_q[REG_DEDICADO];
   assign Ocupado      = ocupado_q;
   assign ErroEscrita  = erro_q;

endmodule
